// File: rtl/vector_exec_pipe.sv
// Two-stage pipelined element-wise vector ALU (SEW 8/16/32) with valid/ready on both sides.
// Define VEC_MUL_EN to enable op 110 (low-half multiply); without it op 110 is illegal and no multiplier is built.
module vector_exec_pipe #(
  parameter int VLEN  = 256,
  parameter int TAG_W = 5,
  localparam int VL_W = $clog2(VLEN/8) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_sew,
  input  logic [VL_W-1:0]  in_vl,
  input  logic [VLEN-1:0]  in_a,
  input  logic [VLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [1:0]       s1_sew;
  logic [VL_W-1:0]  s1_vl;
  logic [VLEN-1:0]  s1_a;
  logic [VLEN-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic             s1_adv;
  logic             s2_adv;

  logic             legal;
  logic [VL_W-1:0]  lim;
  logic [VL_W-1:0]  vl_c;
  logic [31:0]      r;
  logic [VLEN-1:0]  res;
  logic             zero;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Operands are sign-extended from SEW so one 32-bit datapath serves every width;
  // callers keep only the low SEW bits, which makes add/sub/mul wrap per element.
  function automatic logic [31:0] elem_op(input logic [2:0] op, input logic [1:0] sew,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        o;
    case (sew)
      2'b00:   begin sa = {{24{a[7]}}, a[7:0]};   sb = {{24{b[7]}}, b[7:0]};   end
      2'b01:   begin sa = {{16{b[15]}} & 16'h0, a[15:0]} | {{16{a[15]}}, 16'h0};
                     sb = {{16{b[15]}}, b[15:0]}; end
      default: begin sa = a; sb = b; end
    endcase
    case (op)
      3'b000:  o = a + b;
      3'b001:  o = a - b;
      3'b010:  o = a & b;
      3'b011:  o = a | b;
      3'b101:  o = {31'b0, (sa < sb)};
`ifdef VEC_MUL_EN
      3'b110:  o = a * b;
`endif
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    legal = 1'b0;
    case (s1_op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: legal = 1'b1;
`ifdef VEC_MUL_EN
      3'b110: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    if (s1_sew == 2'b11) legal = 1'b0;

    case (s1_sew)
      2'b00:   lim = VL_W'(VLEN/8);
      2'b01:   lim = VL_W'(VLEN/16);
      default: lim = VL_W'(VLEN/32);
    endcase
    vl_c = (s1_vl > lim) ? lim : s1_vl;

    res  = s1_a;
    zero = legal;
    r    = '0;
    if (legal) begin
      case (s1_sew)
        2'b00: begin
          for (int i = 0; i < VLEN/8; i++) begin
            if (i < int'(vl_c)) begin
              r = elem_op(s1_op, s1_sew, 32'(s1_a[i*8 +: 8]), 32'(s1_b[i*8 +: 8]));
              res[i*8 +: 8] = r[7:0];
              if (r[7:0] != 8'h0) zero = 1'b0;
            end
          end
        end
        2'b01: begin
          for (int i = 0; i < VLEN/16; i++) begin
            if (i < int'(vl_c)) begin
              r = elem_op(s1_op, s1_sew, 32'(s1_a[i*16 +: 16]), 32'(s1_b[i*16 +: 16]));
              res[i*16 +: 16] = r[15:0];
              if (r[15:0] != 16'h0) zero = 1'b0;
            end
          end
        end
        default: begin
          for (int i = 0; i < VLEN/32; i++) begin
            if (i < int'(vl_c)) begin
              r = elem_op(s1_op, s1_sew, s1_a[i*32 +: 32], s1_b[i*32 +: 32]);
              res[i*32 +: 32] = r;
              if (r != 32'h0) zero = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_sew   <= '0;
      s1_vl    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_sew <= in_sew;
        s1_vl  <= in_vl;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= res;
        out_zero    <= zero;
        out_illegal <= !legal;
        out_tag     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_vector_exec_pipe.sv
// Scoreboard bench for vector_exec_pipe: directed ops push expectations, a monitor pops on each output transfer.
module tb_vector_exec_pipe;

  localparam int VLEN  = 256;
  localparam int TAG_W = 5;
  localparam int VL_W  = $clog2(VLEN/8) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [1:0]       in_sew = '0;
  logic [VL_W-1:0]  in_vl = '0;
  logic [VLEN-1:0]  in_a = '0;
  logic [VLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [VLEN-1:0]  out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [VLEN-1:0]  res;
    logic             zero;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  vector_exec_pipe #(.VLEN(VLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sew(in_sew), .in_vl(in_vl),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: tag %0d with no pending op", out_tag);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result_tag%0d", e.tag), out_result, e.res);
          chk($sformatf("zero_tag%0d", e.tag), VLEN'(out_zero), VLEN'(e.zero));
          chk($sformatf("illegal_tag%0d", e.tag), VLEN'(out_illegal), VLEN'(e.ill));
          chk($sformatf("tag_order_exp%0d", e.tag), VLEN'(out_tag), VLEN'(e.tag));
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [1:0] sew, input logic [VL_W-1:0] vl,
                      input logic [VLEN-1:0] a, input logic [VLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [VLEN-1:0] er, input logic ez, input logic ei, input bit push);
    exp_t e;
    int   n;
    logic acc;
    e.res = er; e.zero = ez; e.ill = ei; e.tag = tag;
    if (push) sb.push_back(e);
    in_valid = 1'b1; in_op = op; in_sew = sew; in_vl = vl;
    in_a = a; in_b = b; in_tag = tag;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", tag);
        $fatal(1, "handshake timeout");
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", VLEN'(sb.size()), '0);
  endtask

  initial begin
    int   n;
    logic seen_low;
    logic [VLEN-1:0] pat;
    pat = {8{32'h1234_5678}} ^ {32{8'hA5}};

    // reset held three cycles
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", VLEN'(out_valid), '0);
      chk("rst_out_result", out_result, '0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", VLEN'(in_ready), VLEN'(1));
    chk("post_rst_out_valid", VLEN'(out_valid), '0);
    chk("post_rst_out_result", out_result, '0);
    @(posedge clk);
    #1;

    // add sew32, carry must not leak between lanes; two-edge latency
    send(3'b000, 2'b10, 6'd8, {8{32'hFFFF_FFFF}}, {8{32'h1}}, 5'd10, '0, 1'b1, 1'b0, 1'b1);
    chk("lat_after_accept_edge", VLEN'(out_valid), '0);
    @(posedge clk);
    #1;
    chk("lat_after_second_edge", VLEN'(out_valid), VLEN'(1));
    drain();

    send(3'b001, 2'b00, 6'd3, {32{8'h05}}, {32{8'h07}}, 5'd11,
         {{29{8'h05}}, {3{8'hFE}}}, 1'b0, 1'b0, 1'b1);
    send(3'b101, 2'b01, 6'd40, {16{16'h8000}}, {16{16'h0001}}, 5'd12,
         {16{16'h0001}}, 1'b0, 1'b0, 1'b1);
    send(3'b000, 2'b01, 6'd16, {16{16'hFFFF}}, {16{16'h0001}}, 5'd13, '0, 1'b1, 1'b0, 1'b1);
    send(3'b011, 2'b00, 6'd32, {32{8'hF0}}, {32{8'h0F}}, 5'd14, {32{8'hFF}}, 1'b0, 1'b0, 1'b1);
    send(3'b000, 2'b10, 6'd5, {8{32'h7FFF_FFFF}}, {8{32'h1}}, 5'd15,
         {{3{32'h7FFF_FFFF}}, {5{32'h8000_0000}}}, 1'b0, 1'b0, 1'b1);
    send(3'b101, 2'b00, 6'd32, {32{8'h01}}, {32{8'hFF}}, 5'd16, '0, 1'b1, 1'b0, 1'b1);
    send(3'b001, 2'b00, 6'd4, {32{8'h11}}, {32{8'h11}}, 5'd17,
         {{28{8'h11}}, {4{8'h00}}}, 1'b1, 1'b0, 1'b1);
    send(3'b010, 2'b00, 6'd0, pat, {32{8'h00}}, 5'd18, pat, 1'b1, 1'b0, 1'b1);
    send(3'b000, 2'b11, 6'd8, pat, {32{8'h01}}, 5'd19, pat, 1'b0, 1'b1, 1'b1);
    send(3'b111, 2'b10, 6'd8, pat, {32{8'h01}}, 5'd20, pat, 1'b0, 1'b1, 1'b1);
`ifdef VEC_MUL_EN
    send(3'b110, 2'b10, 6'd8, {8{32'd3}}, {8{32'd3}}, 5'd21, {8{32'd9}}, 1'b0, 1'b0, 1'b1);
`else
    send(3'b110, 2'b10, 6'd8, {8{32'd3}}, {8{32'd3}}, 5'd21, {8{32'd3}}, 1'b0, 1'b1, 1'b1);
`endif
    drain();

    // back-to-back stream with a three-cycle output stall
    seen_low = 1'b0;
    fork
      begin
        send(3'b000, 2'b10, 6'd8, {8{32'h1}}, {8{32'h100}}, 5'd1, {8{32'h101}}, 1'b0, 1'b0, 1'b1);
        send(3'b000, 2'b10, 6'd8, {8{32'h2}}, {8{32'h100}}, 5'd2, {8{32'h102}}, 1'b0, 1'b0, 1'b1);
        send(3'b000, 2'b10, 6'd8, {8{32'h3}}, {8{32'h100}}, 5'd3, {8{32'h103}}, 1'b0, 1'b0, 1'b1);
        send(3'b000, 2'b10, 6'd8, {8{32'h4}}, {8{32'h100}}, 5'd4, {8{32'h104}}, 1'b0, 1'b0, 1'b1);
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 20);
        chk("stream_first_valid", VLEN'(out_valid), VLEN'(1));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (!in_ready) seen_low = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    chk("stall_in_ready_low", VLEN'(seen_low), VLEN'(1));
    drain();

    // reset during an in-flight op discards it immediately
    out_ready = 1'b0;
    send(3'b000, 2'b00, 6'd32, {32{8'h01}}, {32{8'h01}}, 5'd25, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", VLEN'(out_valid), VLEN'(1));
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", VLEN'(out_valid), '0);
    chk("async_rst_result", out_result, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ghost_after_rst", VLEN'(out_valid), '0);
    end

    // one op after the mid-run reset still flows
    send(3'b010, 2'b01, 6'd16, {16{16'hF0F0}}, {16{16'h0FF0}}, 5'd26, {16{16'h00F0}}, 1'b0, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
